icache_fetcher: RTL
===================

Name: icache_fetcher

Overview:
- Instruction-fetch front end: holds the PC and a direct-mapped, one-word-per-line instruction cache.
- Supplies instructions to the instruction queue/decoder.
- On a cache miss, requests a 32-bit word from the memory controller's fetcher port (ce/addr request, one-cycle done pulse plus data bus). Fills the line, then issues from the cache.
- Redirects on a ROB misbranch.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- INDEX_BITS, 8, cache index width; 2^INDEX_BITS lines. Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global enable; when low, all state holds.
- out_mem_ce  output  1  fetch request to memory controller, level-held until served.
- out_mem_addr  output  32  byte address of requested word; stable while out_mem_ce=1.
- in_mem_ce  input  1  one-cycle pulse: requested word is on in_mem_data.
- in_mem_data  input  32  little-endian instruction word from memory controller.
- in_queue_full  input  1  downstream cannot accept an instruction this cycle.
- out_inst_valid  output  1  one-cycle pulse per issued instruction.
- out_inst  output  32  instruction word.
- out_pc  output  32  PC of out_inst.
- in_rob_misbranch  input  1  flush and redirect.
- in_rob_newpc  input  32  redirect target, valid with in_rob_misbranch.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, all line valid bits=0, state=IDLE.
  - out_mem_ce=0, out_mem_addr=0, out_inst_valid=0, out_inst=0, out_pc=0.
- rdy=0 (rst=0): no register changes; out_inst_valid holds its value. rst has priority over rdy.
- Default each enabled cycle: out_inst_valid<=0.
- State IDLE:
  - Hit = valid[idx(pc)] && tag[idx(pc)]==tag(pc), combinational from current pc.
  - Hit and !in_queue_full: out_inst_valid<=1, out_inst<=data[idx], out_pc<=pc, pc<=pc+4 (mod 2^32). Sustains one instruction per cycle on consecutive hits.
  - Hit and in_queue_full: no issue, pc unchanged.
  - Miss: out_mem_ce<=1, out_mem_addr<=pc, state<=WAIT. Issued regardless of in_queue_full (prefetch).
- State WAIT:
  - Hold out_mem_ce=1 and out_mem_addr.
  - On in_mem_ce=1: data/tag of idx(out_mem_addr)<=in_mem_data/tag, valid<=1, out_mem_ce<=0, state<=IDLE.
  - No issue in the fill cycle; the next cycle hits.
  - Miss-to-issue latency: 1 cycle (request) + memory latency + 1 cycle (fill) + 1 cycle (hit issue).
- Misbranch (in_rob_misbranch=1, rdy=1), highest priority after rst:
  - pc<=in_rob_newpc, state<=IDLE, out_mem_ce<=0, out_inst_valid<=0.
  - in_mem_ce arriving in the same cycle is ignored: no fill, no issue.
  - Cache contents are preserved.
  - Normal fetch resumes the following cycle.
- The memory controller may return at most one in_mem_ce per request. in_mem_ce while in IDLE (stale) is ignored.
- Conflict misses: a fill overwrites the line unconditionally; there is no replacement choice.
- No self-modifying-code coherence: the cache is never invalidated except by rst.
- Misaligned pc (pc[1:0]!=0) is not checked; the low bits are ignored for index/tag but passed through on out_pc.

Test Plan:
1. Reset, then memory returns 32'h00000013 for addr 0 after 5 cycles -> out_mem_ce=1 with addr 0 one cycle after reset release; fill; out_inst_valid with inst=32'h13, pc=0 two cycles after in_mem_ce; next request addr 4.
2. Loop re-executing addresses 0x0-0xC, already cached, with in_queue_full=0 -> four consecutive out_inst_valid pulses (pc 0,4,8,C), no out_mem_ce.
3. Hit stream with in_queue_full=1 for 3 cycles -> no out_inst_valid; pc held; issue resumes with the same pc the cycle full drops.
4. Misbranch to 0x100 while WAIT on 0x10, with in_mem_ce in the same cycle -> out_mem_ce=0 next cycle, line for 0x10 stays invalid, next request addr 0x100.
5. Fill 0x0, then fetch 0x400 (same index, INDEX_BITS=8) -> miss on 0x400; after fill, fetching 0x0 misses again.
6. rdy=0 for 4 cycles mid-WAIT, with in_mem_ce held low -> all outputs frozen; after rdy=1 the fill completes normally.

Source files
------------

// File: rtl/icache_fetcher.sv
// icache_fetcher: PC register plus a direct-mapped, one-word-per-line instruction cache
// that feeds the instruction queue and refills from the memory controller on a miss.
module icache_fetcher #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_mem_ce,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ce,
  input  logic [31:0] in_mem_data,
  input  logic        in_queue_full,
  output logic        out_inst_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        in_rob_misbranch,
  input  logic [31:0] in_rob_newpc
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [31:0] pc;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0] data [LINES];
  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic hit, fill;
  assign idx      = pc[INDEX_BITS+1:2];
  assign fill_idx = out_mem_addr[INDEX_BITS+1:2];
  assign hit      = valid[idx] && tags[idx] == pc[31:INDEX_BITS+2];
  // A return coinciding with a misbranch is dropped, so the line stays untouched.
  assign fill     = !rst && rdy && !in_rob_misbranch && state == WAIT && in_mem_ce;
  always_ff @(posedge clk)
    if (fill) begin
      tags[fill_idx] <= out_mem_addr[31:INDEX_BITS+2];
      data[fill_idx] <= in_mem_data;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      valid          <= '0;
      state          <= IDLE;
      out_mem_ce     <= 1'b0;
      out_mem_addr   <= '0;
      out_inst_valid <= 1'b0;
      out_inst       <= '0;
      out_pc         <= '0;
    end else if (rdy) begin
      out_inst_valid <= 1'b0;
      if (in_rob_misbranch) begin
        pc         <= in_rob_newpc;
        state      <= IDLE;
        out_mem_ce <= 1'b0;
      end else if (state == IDLE) begin
        if (!hit) begin
          out_mem_ce   <= 1'b1;
          out_mem_addr <= pc;
          state        <= WAIT;
        end else if (!in_queue_full) begin
          out_inst_valid <= 1'b1;
          out_inst       <= data[idx];
          out_pc         <= pc;
          pc             <= pc + 32'd4;
        end
      end else if (in_mem_ce) begin
        valid[fill_idx] <= 1'b1;
        out_mem_ce      <= 1'b0;
        state           <= IDLE;
      end
    end
  end
endmodule
